// File: rtl/acc_neuron_slave.sv
// acc_neuron_slave
//   Bus-mapped 16-tap Q8.8 multiply-accumulate neuron with ReLU and saturation.
//   The CPU fills the input, weight and bias buffers over the bus. It raises
//   start, polls done, and reads the result back.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   iBusWrite    : one-cycle write strobe (DbStore)
//   iBusRead     : one-cycle read strobe (DbLoad)
//   iBusAddr     : word address
//   iBusData     : write data
//   oBusData     : registered read data; holds until the next read
//   iACC_en      : enable level; low forces IDLE from any state
//   iACC_start   : start level; only a rising edge launches a run
//   oACC_done    : high while the FSM sits in DONE
//
// Address map
//   0x00-0x0F x[i] R/W, 0x10-0x1F w[i] R/W, 0x20 bias R/W,
//   0x21 result RO, 0x22 status RO {14'b0, busy, done}, others read 0.
//   Buffer writes are dropped while busy (RUN or FINISH).
//
// Handshake: a bus strobe is a single-cycle valid with no ready. The slave
// always accepts it on the sampling edge, and read data appears one cycle later.
module acc_neuron_slave #(
  parameter int N_TAPS = 16,
  parameter int FRAC   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iBusWrite,
  input  logic        iBusRead,
  input  logic [7:0]  iBusAddr,
  input  logic [15:0] iBusData,
  output logic [15:0] oBusData,
  input  logic        iACC_en,
  input  logic        iACC_start,
  output logic        oACC_done
);

  localparam int ACC_W = 36;
  localparam int IDX_W = $clog2(N_TAPS);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t state, nextState;

  logic signed [15:0]      xMem [N_TAPS];
  logic signed [15:0]      wMem [N_TAPS];
  logic signed [15:0]      bias;
  logic        [15:0]      result;
  logic signed [ACC_W-1:0] acc;
  logic        [IDX_W-1:0] idx;
  logic                    start_q;

  logic                    startEdge;
  logic                    loadAcc;
  logic                    doMac;
  logic                    writeRes;
  logic                    busy;
  logic signed [31:0]      prod;
  logic        [15:0]      satResult;
  logic        [15:0]      rdData;
  logic                    wrOk;

  assign startEdge = iACC_start && !start_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; a low enable overrides every transition.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startEdge) nextState = RUN;
      RUN:     if (idx == IDX_W'(N_TAPS - 1)) nextState = FINISH;
      FINISH:  nextState = DONE;
      DONE:    if (!iACC_start) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (!iACC_en) nextState = IDLE;
  end

  // Output / datapath-control decode
  always_comb begin
    loadAcc   = 1'b0;
    doMac     = 1'b0;
    writeRes  = 1'b0;
    busy      = 1'b0;
    oACC_done = 1'b0;
    case (state)
      IDLE:    loadAcc = iACC_en && startEdge;
      RUN:     begin doMac = iACC_en; busy = 1'b1; end
      FINISH:  begin writeRes = iACC_en; busy = 1'b1; end
      DONE:    oACC_done = 1'b1;
      default: ;
    endcase
  end

  assign prod = xMem[idx] * wMem[idx];

  // ReLU, then clamp to the largest positive Q8.8, else truncate the low FRAC bits.
  always_comb begin
    if (acc[ACC_W-1])
      satResult = 16'h0000;
    else if (acc[ACC_W-1:FRAC] > (ACC_W-FRAC)'(16'h7FFF))
      satResult = 16'h7FFF;
    else
      satResult = acc[FRAC+15:FRAC];
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      idx     <= '0;
      start_q <= 1'b0;
      result  <= '0;
    end else begin
      start_q <= iACC_start;
      if (loadAcc) begin
        acc <= {{(ACC_W-16-FRAC){bias[15]}}, bias, {FRAC{1'b0}}};
        idx <= '0;
      end else if (doMac) begin
        acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
        idx <= idx + 1'b1;
      end
      if (writeRes) result <= satResult;
    end
  end

  // Bus write side
  assign wrOk = iBusWrite && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        xMem[i] <= '0;
        wMem[i] <= '0;
      end
      bias <= '0;
    end else if (wrOk) begin
      if (iBusAddr[7:5] == 3'b000) begin
        if (iBusAddr[4]) wMem[iBusAddr[3:0]] <= iBusData;
        else             xMem[iBusAddr[3:0]] <= iBusData;
      end else if (iBusAddr == 8'h20) begin
        bias <= iBusData;
      end
    end
  end

  // Bus read side; the mux sees pre-edge values, so same-cycle read/write returns old data.
  always_comb begin
    rdData = 16'h0000;
    if (iBusAddr[7:5] == 3'b000) begin
      if (iBusAddr[4]) rdData = wMem[iBusAddr[3:0]];
      else             rdData = xMem[iBusAddr[3:0]];
    end else begin
      case (iBusAddr)
        8'h20:   rdData = bias;
        8'h21:   rdData = result;
        8'h22:   rdData = {14'b0, busy, oACC_done};
        default: rdData = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        oBusData <= '0;
    else if (iBusRead) oBusData <= rdData;
  end

endmodule

// File: tb/tb_acc_neuron_slave.sv
module tb_acc_neuron_slave;

  logic        clk;
  logic        rst_n;
  logic        iBusWrite;
  logic        iBusRead;
  logic [7:0]  iBusAddr;
  logic [15:0] iBusData;
  logic [15:0] oBusData;
  logic        iACC_en;
  logic        iACC_start;
  logic        oACC_done;

  int nCompared;
  int nMismatched;

  acc_neuron_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iBusWrite  (iBusWrite),
    .iBusRead   (iBusRead),
    .iBusAddr   (iBusAddr),
    .iBusData   (iBusData),
    .oBusData   (oBusData),
    .iACC_en    (iACC_en),
    .iACC_start (iACC_start),
    .oACC_done  (oACC_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Driver tasks: all are entered and left on a falling edge.
  task automatic busWrite(input logic [7:0] addr, input logic [15:0] data);
    iBusWrite = 1'b1;
    iBusAddr  = addr;
    iBusData  = data;
    @(negedge clk);
    iBusWrite = 1'b0;
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [15:0] data);
    iBusRead = 1'b1;
    iBusAddr = addr;
    @(negedge clk);
    iBusRead = 1'b0;
    data = oBusData;
  endtask

  task automatic loadAll(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < 16; i++) begin
      busWrite(8'(i), xv);
      busWrite(8'(16 + i), wv);
    end
    busWrite(8'h20, bv);
  endtask

  // Count cycles after the start-sampling edge until done rises (bounded).
  task automatic waitDone(input string tag, output int n);
    n = 0;
    while (!oACC_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, "_done_seen"}, {15'b0, oACC_done}, 16'h0001);
  endtask

  // Raise start, wait for done, read result, drop start and check done falls.
  task automatic runAndCheck(input string tag, input logic [15:0] expRes);
    int n;
    logic [15:0] rd;
    iACC_start = 1'b1;
    @(negedge clk);
    waitDone(tag, n);
    busRead(8'h21, rd);
    checkVal({tag, "_result"}, rd, expRes);
    iACC_start = 1'b0;
    @(negedge clk);
    checkVal({tag, "_done_fall"}, {15'b0, oACC_done}, 16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    int n;
    nCompared   = 0;
    nMismatched = 0;
    rst_n      = 1'b0;
    iBusWrite  = 1'b0;
    iBusRead   = 1'b0;
    iBusAddr   = 8'h00;
    iBusData   = 16'h0000;
    iACC_en    = 1'b0;
    iACC_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    checkVal("rst_busdata", oBusData, 16'h0000);
    checkVal("rst_done", {15'b0, oACC_done}, 16'h0000);
    busRead(8'h21, rd); checkVal("rst_result", rd, 16'h0000);
    busRead(8'h05, rd); checkVal("rst_x5", rd, 16'h0000);
    busRead(8'h22, rd); checkVal("rst_status", rd, 16'h0000);

    // Same-cycle read and write returns the old value; the new one lands next cycle.
    iBusWrite = 1'b1; iBusRead = 1'b1; iBusAddr = 8'h20; iBusData = 16'h5555;
    @(negedge clk);
    iBusWrite = 1'b0; iBusRead = 1'b0;
    checkVal("rw_same_old", oBusData, 16'h0000);
    busRead(8'h20, rd); checkVal("rw_same_new", rd, 16'h5555);
    busWrite(8'h13, 16'hA5A5);
    busRead(8'h13, rd); checkVal("w3_readback", rd, 16'hA5A5);

    // Computation and latency: 16 * 1.0 * 1.0 = 16.0
    iACC_en = 1'b1;
    loadAll(16'h0100, 16'h0100, 16'h0000);
    iACC_start = 1'b1;
    @(negedge clk);
    waitDone("lat", n);
    checkVal("lat_cycles", 16'(n), 16'd17);
    busRead(8'h21, rd); checkVal("lat_result", rd, 16'h1000);
    busRead(8'h22, rd); checkVal("lat_status", rd, 16'h0001);
    iACC_start = 1'b0;
    @(negedge clk);
    checkVal("lat_done_fall", {15'b0, oACC_done}, 16'h0000);

    // ReLU: 16 * -1.0 + 2.0 < 0
    loadAll(16'h0100, 16'hFF00, 16'h0200);
    runAndCheck("relu", 16'h0000);

    // Saturation
    loadAll(16'h7FFF, 16'h7FFF, 16'h7FFF);
    runAndCheck("sat", 16'h7FFF);

    // Mixed signs: 1.5 * 0.5 - 0.5 = 0.25
    loadAll(16'h0000, 16'h0000, 16'hFF80);
    busWrite(8'h00, 16'h0180);
    busWrite(8'h10, 16'h0080);
    runAndCheck("mixed", 16'h0040);

    // Write protection during RUN
    loadAll(16'h0100, 16'h0100, 16'h0000);
    iACC_start = 1'b1;
    @(negedge clk);
    busWrite(8'h00, 16'h7FFF);
    busWrite(8'h21, 16'h1234);
    busRead(8'h22, rd); checkVal("wp_status_busy", rd, 16'h0002);
    waitDone("wp", n);
    busRead(8'h21, rd); checkVal("wp_result", rd, 16'h1000);
    busRead(8'h00, rd); checkVal("wp_x0", rd, 16'h0100);
    busWrite(8'h40, 16'hBEEF);
    busRead(8'h40, rd); checkVal("wp_unmapped", rd, 16'h0000);
    iACC_start = 1'b0;
    @(negedge clk);

    // Abort: the run would produce 0x1100, so the old 0x1000 must survive.
    busWrite(8'h00, 16'h0200);
    iACC_start = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    iACC_en = 1'b0;
    @(negedge clk);
    checkVal("abort_done", {15'b0, oACC_done}, 16'h0000);
    busRead(8'h22, rd); checkVal("abort_status", rd, 16'h0000);
    busRead(8'h21, rd); checkVal("abort_result", rd, 16'h1000);

    // Start held high with enable back: no retrigger.
    iACC_en = 1'b1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (oACC_done) n++;
    end
    checkVal("hold_no_run_done", 16'(n), 16'd0);
    busRead(8'h22, rd); checkVal("hold_status", rd, 16'h0000);

    // Fresh rising edge: full run
    iACC_start = 1'b0;
    @(negedge clk);
    iACC_start = 1'b1;
    @(negedge clk);
    waitDone("retrig", n);
    checkVal("retrig_cycles", 16'(n), 16'd17);
    busRead(8'h21, rd); checkVal("retrig_result", rd, 16'h1100);
    iACC_start = 1'b0;
    @(negedge clk);

    // Reset mid-run clears everything, buffers included.
    iACC_start = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("mrst_done", {15'b0, oACC_done}, 16'h0000);
    checkVal("mrst_busdata", oBusData, 16'h0000);
    iACC_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busRead(8'h00, rd); checkVal("mrst_x0", rd, 16'h0000);
    busRead(8'h1F, rd); checkVal("mrst_w15", rd, 16'h0000);
    busRead(8'h20, rd); checkVal("mrst_bias", rd, 16'h0000);
    busRead(8'h21, rd); checkVal("mrst_result", rd, 16'h0000);
    busRead(8'h22, rd); checkVal("mrst_status", rd, 16'h0000);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
